mem_dump_arbiter: RTL and testbench
===================================

# mem_dump_arbiter

Owns the single port of the processor's 128-byte data RAM and shares it between the CPU core and a hardware memory-dump engine. While the program runs, the CPU has the port. When the core raises `done`, the block takes the port and streams all RAM bytes, address 0 upward, over a valid/ready byte interface to the host/debug link. This is the in-silicon equivalent of the simulation-side result dump.

## Interface
- `DEPTH`, 128: number of RAM bytes dumped; must equal 2**`ADDR_W`.
- `ADDR_W`, 7: RAM address width.
- `DATA_W`, 8: RAM data width.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `done`  in  1  program-finished flag from the CPU core.
- `cpu_req`  in  1  CPU requests a RAM access this cycle.
- `cpu_we`  in  1  CPU write enable.
- `cpu_addr`  in  `ADDR_W`  CPU address.
- `cpu_wdata`  in  `DATA_W`  CPU write data.
- `cpu_gnt`  out  1  CPU access accepted this cycle (combinational).
- `cpu_rdata`  out  `DATA_W`  read data, direct pass-through of `ram_rdata`.
- `ram_en`, `ram_we`  out  1 each  RAM port enable and write enable.
- `ram_addr`  out  `ADDR_W`  RAM address.
- `ram_wdata`  out  `DATA_W`  RAM write data.
- `ram_rdata`  in  `DATA_W`  synchronous read data, valid one cycle after `ram_en` with `ram_we`=0.
- `dump_valid`  out  1  `dump_data` holds a byte.
- `dump_data`  out  `DATA_W`  dumped byte.
- `dump_last`  out  1  the current byte is address `DEPTH`-1.
- `dump_ready`  in  1  sink accepts the byte.
- `dump_busy`  out  1  dump engine owns the RAM.
- `dump_complete`  out  1  all bytes have been accepted.

## Operation
- The FSM states are IDLE, READ, CAPTURE, SEND and FINISH. There is a `ptr` counter of width `ADDR_W`, an output register for `dump_data`, and a registered `done_q` for edge detection.
- **IDLE**
  - The CPU owns the port: `cpu_gnt`=`cpu_req`, and `ram_en/we/addr/wdata` follow the `cpu_*` inputs.
  - A rising edge of `done` (`done` & !`done_q`) moves the FSM to READ and clears `ptr` to 0.
- **READ**
  - The FSM drives `ram_en`=1, `ram_we`=0 and `ram_addr`=`ptr`, then moves to CAPTURE.
- **CAPTURE**
  - `ram_rdata` is latched into `dump_data`.
  - `dump_valid` is set, with `dump_last`=(`ptr`==`DEPTH`-1).
  - The FSM moves to SEND.
- **SEND**
  - `dump_valid` and `dump_data` are held stable until `dump_ready`=1.
  - On the handshake, `dump_valid` clears. If `ptr`==`DEPTH`-1 the FSM moves to FINISH; otherwise `ptr`+1 and the FSM moves to READ.
- **FINISH**
  - `dump_complete`=1 and the RAM is idle.
  - The FSM returns to IDLE only when `done`=0. This allows a rerun on the next `done` rise.
- **Arbitration**
  - In every state except IDLE: `cpu_gnt`=0, RAM writes are impossible from the CPU, and `dump_busy`=1.
  - If `cpu_req` and a `done` rise coincide, the CPU gets that cycle (still IDLE) and the dump starts the next cycle.
- `done` falling during a dump is ignored; the dump runs to completion.
- `ptr` never wraps. The terminal test is on `DEPTH`-1, so exactly `DEPTH` bytes are sent per dump.
- `ram_en`=0 in CAPTURE, SEND and FINISH.

## Timing
- Reset (`reset`=0, immediate):
  - state IDLE; `ptr`=0; `done_q`=0; `dump_data`=0.
  - `dump_valid`=`dump_last`=`dump_busy`=`dump_complete`=0.
  - `cpu_gnt`=`cpu_req`.
- A reset asserted mid-dump aborts the dump with no further handshake. Only a fresh `done` rise after reset restarts it.
- Latency from the `done` rise (edge k) to READ is cycle k+1, and the first `dump_valid` is at cycle k+3.
- Each byte takes 3 cycles with `dump_ready` held high. A full dump with continuous ready spans 3·`DEPTH` cycles, and `dump_complete` rises one cycle after the last handshake.
- `dump_ready` low stalls in SEND indefinitely, and `dump_data` must not change during the stall.
- CPU read data appears on `cpu_rdata` one cycle after the grant, per the RAM.

## Test plan
- **CPU phase:** CPU writes 0xA5 to address 0x10 and then reads it back → `cpu_gnt`=1 both cycles; `cpu_rdata`=0xA5 the cycle after the read; `dump_busy`=0.
- **Full dump:** preload RAM[i]=i^0x5A, pulse `done`, hold `dump_ready`=1 → 128 bytes in address order, first at `done`+3 cycles, `dump_last` only on byte 127 (0x25), `dump_complete` after 384 cycles.
- **Backpressure:** random `dump_ready` with 30% duty → byte sequence unchanged; `dump_data` stable while valid & !ready; no byte is lost or duplicated.
- **CPU locked out:** assert `cpu_req` with write 0xFF to address 0 during a dump → `cpu_gnt`=0; RAM[0] unchanged; dumped byte 0 keeps its preloaded value.
- **Reset mid-dump:** drop `reset` after byte 40 → all outputs at reset values immediately; no dump until the next `done` rise, which restarts from address 0.
- **Rerun:** hold `done`=1 after complete → stays in FINISH; drop and raise `done` → second identical 128-byte dump.

Source files
------------

// File: rtl/mem_dump_arbiter.sv
// mem_dump_arbiter
//
// Shares the single port of the processor data RAM between the CPU core and
// a memory-dump engine. While the program runs, the CPU owns the port. A
// rising edge on `done` hands the port to the dump engine. The engine then
// streams every RAM byte, address 0 upward, over a valid/ready byte
// interface.
//
// Ports
//   clock          sole clock, rising edge
//   reset          asynchronous, active-low reset
//   done           program-finished flag from the CPU core
//   cpu_req/we     CPU access request / write enable
//   cpu_addr/wdata CPU address / write data
//   cpu_gnt        CPU access accepted this cycle (combinational)
//   cpu_rdata      RAM read data pass-through
//   ram_en/we      RAM port enable / write enable
//   ram_addr/wdata RAM address / write data
//   ram_rdata      synchronous RAM read data (one cycle after a read)
//   dump_valid     dump_data holds a byte
//   dump_data      dumped byte
//   dump_last      current byte is address DEPTH-1
//   dump_ready     sink accepts the byte
//   dump_busy      dump engine owns the RAM
//   dump_complete  all bytes of the dump have been accepted

module mem_dump_arbiter #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              done,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              dump_valid,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  input  logic              dump_ready,
  output logic              dump_busy,
  output logic              dump_complete
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    FINISH  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic              done_q_reg;
  logic [DATA_W-1:0] dump_data_reg;
  logic              dump_valid_reg;
  logic              dump_last_reg;
  logic              dump_busy_reg;
  logic              dump_complete_reg;
  logic              done_rise;

  assign done_rise = done & ~done_q_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg         <= IDLE;
      ptr_reg           <= '0;
      done_q_reg        <= 1'b0;
      dump_data_reg     <= '0;
      dump_valid_reg    <= 1'b0;
      dump_last_reg     <= 1'b0;
      dump_busy_reg     <= 1'b0;
      dump_complete_reg <= 1'b0;
    end else begin
      done_q_reg <= done;
      case (state_reg)
        IDLE: begin
          // A CPU request on the same cycle as the done rise is still
          // granted, because the port only changes hands on the next cycle.
          if (done_rise) begin
            state_reg     <= READ;
            ptr_reg       <= '0;
            dump_busy_reg <= 1'b1;
          end
        end
        READ: begin
          state_reg <= CAPTURE;
        end
        CAPTURE: begin
          dump_data_reg  <= ram_rdata;
          dump_valid_reg <= 1'b1;
          dump_last_reg  <= (ptr_reg == LAST_ADDR);
          state_reg      <= SEND;
        end
        SEND: begin
          if (dump_ready) begin
            dump_valid_reg <= 1'b0;
            dump_last_reg  <= 1'b0;
            // The terminal test comes before the increment, so ptr never
            // wraps and exactly DEPTH bytes are sent.
            if (ptr_reg == LAST_ADDR) begin
              state_reg         <= FINISH;
              dump_complete_reg <= 1'b1;
            end else begin
              ptr_reg   <= ptr_reg + 1'b1;
              state_reg <= READ;
            end
          end
        end
        FINISH: begin
          // Wait for done to drop so that the next rise can start a rerun.
          if (!done) begin
            state_reg         <= IDLE;
            dump_complete_reg <= 1'b0;
            dump_busy_reg     <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Port mux: the CPU drives the RAM only in IDLE. The dump engine reads
  // only in READ, and the port is otherwise quiet.
  always_comb begin
    cpu_gnt   = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = ptr_reg;
    ram_wdata = '0;
    case (state_reg)
      IDLE: begin
        cpu_gnt   = cpu_req;
        ram_en    = cpu_req;
        ram_we    = cpu_req & cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
      READ: begin
        ram_en = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign cpu_rdata     = ram_rdata;
  assign dump_valid    = dump_valid_reg;
  assign dump_data     = dump_data_reg;
  assign dump_last     = dump_last_reg;
  assign dump_busy     = dump_busy_reg;
  assign dump_complete = dump_complete_reg;

endmodule

// File: tb/tb_mem_dump_arbiter.sv
// Testbench for mem_dump_arbiter. It holds a behavioural 128-byte RAM with
// synchronous read. Stimulus pushes the expected dump bytes into a queue,
// and a monitor pops and compares them on every dump handshake.

module tb_mem_dump_arbiter;

  logic       clock;
  logic       reset;
  logic       done;
  logic       cpu_req;
  logic       cpu_we;
  logic [6:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_gnt;
  logic [7:0] cpu_rdata;
  logic       ram_en;
  logic       ram_we;
  logic [6:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       dump_valid;
  logic [7:0] dump_data;
  logic       dump_last;
  logic       dump_ready;
  logic       dump_busy;
  logic       dump_complete;

  mem_dump_arbiter #(.DEPTH(128), .ADDR_W(7), .DATA_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .done         (done),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_gnt      (cpu_gnt),
    .cpu_rdata    (cpu_rdata),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .dump_valid   (dump_valid),
    .dump_data    (dump_data),
    .dump_last    (dump_last),
    .dump_ready   (dump_ready),
    .dump_busy    (dump_busy),
    .dump_complete(dump_complete)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural RAM with synchronous read.
  logic [7:0] mem [0:127];
  always @(posedge clock) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int rx_count = 0;
  int rdy_mode = 0;   // 0: ready low, 1: ready high, 2: random 30% duty
  logic [8:0] exp_q[$];  // {last, data}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Expected dump content after preload: RAM[i] = i ^ 0x5A.
  task automatic push_dump();
    for (int i = 0; i < 128; i++) begin
      logic [7:0] b;
      b = 8'(i) ^ 8'h5A;
      exp_q.push_back({(i == 127), b});
    end
  endtask

  task automatic pulse_done(input bit hold);
    @(posedge clock); #1 done = 1'b1;
    @(posedge clock); #1 if (!hold) done = 1'b0;
  endtask

  task automatic wait_complete(input int bound);
    int n;
    n = 0;
    while (n < bound) begin
      @(negedge clock);
      n++;
      if (dump_complete) break;
    end
    check("complete_seen", {31'd0, dump_complete}, 32'd1);
  endtask

  // Ready driver.
  initial begin
    dump_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0:       dump_ready = 1'b0;
        1:       dump_ready = 1'b1;
        default: dump_ready = ($urandom_range(0, 99) < 30);
      endcase
    end
  end

  // Monitor: a handshake takes place at the next rising edge whenever valid
  // and ready are both seen at the falling edge.
  initial begin
    logic       hold_pending;
    logic [7:0] hold_data;
    logic [8:0] e;
    hold_pending = 1'b0;
    hold_data    = '0;
    forever begin
      @(negedge clock);
      if (reset && dump_valid) begin
        if (hold_pending)
          check("hold_stable", {24'd0, dump_data}, {24'd0, hold_data});
        if (dump_ready) begin
          hold_pending = 1'b0;
          if (exp_q.size() == 0) begin
            check("extra_byte", {23'd0, dump_last, dump_data}, 32'h1FF);
          end else begin
            e = exp_q.pop_front();
            check("dump_byte", {23'd0, dump_last, dump_data}, {23'd0, e});
          end
          rx_count++;
        end else begin
          hold_pending = 1'b1;
          hold_data    = dump_data;
        end
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  initial begin
    int n;
    int base;
    reset     = 1'b0;
    done      = 1'b0;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;

    // Reset state
    #12;
    check("rst_valid",    {31'd0, dump_valid},    32'd0);
    check("rst_last",     {31'd0, dump_last},     32'd0);
    check("rst_busy",     {31'd0, dump_busy},     32'd0);
    check("rst_complete", {31'd0, dump_complete}, 32'd0);
    check("rst_data",     {24'd0, dump_data},     32'd0);
    check("rst_gnt",      {31'd0, cpu_gnt},       32'd1);
    cpu_req = 1'b0;
    @(posedge clock); #1 reset = 1'b1;

    // CPU phase: write 0xA5 to 0x10, then read it back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h10; cpu_wdata = 8'hA5;
    @(negedge clock);
    check("cpu_wr_gnt",  {31'd0, cpu_gnt},  32'd1);
    check("cpu_wr_we",   {31'd0, ram_we},   32'd1);
    check("cpu_wr_addr", {25'd0, ram_addr}, 32'h10);
    check("cpu_busy",    {31'd0, dump_busy}, 32'd0);
    @(posedge clock); #1 cpu_we = 1'b0;
    @(negedge clock);
    check("cpu_rd_gnt", {31'd0, cpu_gnt}, 32'd1);
    check("cpu_rd_en",  {31'd0, ram_en},  32'd1);
    @(posedge clock); #1 cpu_req = 1'b0;
    @(negedge clock);
    check("cpu_rdata", {24'd0, cpu_rdata}, 32'hA5);

    // Preload RAM[i] = i ^ 0x5A through the CPU port
    for (int i = 0; i < 128; i++) begin
      @(posedge clock); #1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'(i); cpu_wdata = 8'(i) ^ 8'h5A;
    end
    @(posedge clock); #1 cpu_req = 1'b0; cpu_we = 1'b0;

    // Full dump with continuous ready, checking the latency and the total span
    rdy_mode = 1;
    push_dump();
    pulse_done(1'b0);
    @(negedge clock);
    check("read_busy",  {31'd0, dump_busy},  32'd1);
    check("read_en",    {31'd0, ram_en},     32'd1);
    check("read_we",    {31'd0, ram_we},     32'd0);
    check("read_addr",  {25'd0, ram_addr},   32'd0);
    check("read_valid", {31'd0, dump_valid}, 32'd0);
    @(negedge clock);
    check("capture_valid", {31'd0, dump_valid}, 32'd0);
    check("capture_en",    {31'd0, ram_en},     32'd0);
    @(negedge clock);
    check("first_valid", {31'd0, dump_valid}, 32'd1);
    n = 2;
    while (n < 500) begin
      @(negedge clock);
      n++;
      if (dump_complete) break;
    end
    check("complete_cycle", 32'(n), 32'd384);
    check("full_all_bytes", 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    check("idle_after_busy",     {31'd0, dump_busy},     32'd0);
    check("idle_after_complete", {31'd0, dump_complete}, 32'd0);

    // Backpressure with the CPU locked out
    rdy_mode = 2;
    push_dump();
    pulse_done(1'b0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h00; cpu_wdata = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("lock_gnt", {31'd0, cpu_gnt}, 32'd0);
      check("lock_we",  {31'd0, ram_we},  32'd0);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    wait_complete(5000);
    check("bp_all_bytes", 32'(exp_q.size()), 32'd0);
    rdy_mode = 1;
    @(posedge clock); #1 cpu_req = 1'b1; cpu_addr = 7'h00;
    @(posedge clock); #1 cpu_req = 1'b0;
    @(negedge clock);
    check("ram0_kept", {24'd0, cpu_rdata}, 32'h5A);

    // Rerun: hold done high after the dump has completed, then drop and raise it
    push_dump();
    pulse_done(1'b1);
    wait_complete(1000);
    repeat (10) @(negedge clock);
    check("finish_hold_complete", {31'd0, dump_complete}, 32'd1);
    check("finish_hold_busy",     {31'd0, dump_busy},     32'd1);
    check("finish_ram_en",        {31'd0, ram_en},        32'd0);
    done = 1'b0;
    @(negedge clock);
    check("rerun_idle_complete", {31'd0, dump_complete}, 32'd0);
    check("rerun_idle_busy",     {31'd0, dump_busy},     32'd0);
    push_dump();
    pulse_done(1'b0);
    wait_complete(1000);
    check("rerun_all_bytes", 32'(exp_q.size()), 32'd0);

    // Reset asserted after byte 40 has been accepted
    push_dump();
    base = rx_count;
    pulse_done(1'b0);
    n = 0;
    while (n < 1000 && rx_count < base + 41) begin
      @(posedge clock);
      n++;
    end
    check("mid_bytes_reached", 32'(rx_count - base), 32'd41);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_valid",    {31'd0, dump_valid},    32'd0);
    check("mid_rst_busy",     {31'd0, dump_busy},     32'd0);
    check("mid_rst_data",     {24'd0, dump_data},     32'd0);
    check("mid_rst_last",     {31'd0, dump_last},     32'd0);
    check("mid_rst_complete", {31'd0, dump_complete}, 32'd0);
    exp_q.delete();
    @(posedge clock); #1 reset = 1'b1;
    repeat (10) @(negedge clock);
    check("post_rst_busy",  {31'd0, dump_busy},  32'd0);
    check("post_rst_valid", {31'd0, dump_valid}, 32'd0);
    push_dump();
    pulse_done(1'b0);
    wait_complete(1000);
    check("restart_all_bytes", 32'(exp_q.size()), 32'd0);

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
